// File: rtl/add_subt_normalizer.sv
// Post-adder normalizer: leading-zero count, left/right shift and
// exponent adjust in a three-step FSM ahead of the rounding stage.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load_i         start pulse, accepted only in IDLE
//   Add_Sub_op_i   effective op (0 add, 1 subtract)
//   C_i            carry-out of the mantissa adder
//   Data_i, Exp_i  sum magnitude and biased exponent
//   Data_o, Exp_o  normalized significand and exponent
//   Shift_o        applied left-shift amount (0 on right shift)
//   busy_o         high in COUNT and SHIFT
//   ready_o        one-cycle pulse after the result is complete
//   zero_o, overflow_o, underflow_o  result flags
// Build option: define NORM_STICKY_EN to OR the dropped bit into
// Data_o[0] on a right shift.
module add_subt_normalizer #(
    parameter int SWR = 26,
    parameter int EWR = 8,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           Add_Sub_op_i,
    input  logic           C_i,
    input  logic [SWR-1:0] Data_i,
    input  logic [EWR-1:0] Exp_i,
    output logic [SWR-1:0] Data_o,
    output logic [EWR-1:0] Exp_o,
    output logic [SHW-1:0] Shift_o,
    output logic           busy_o,
    output logic           ready_o,
    output logic           zero_o,
    output logic           overflow_o,
    output logic           underflow_o
);

    localparam int CW = ((EWR > SHW) ? EWR : SHW) + 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SHIFT,
        DONE
    } state_t;

    state_t         state;
    logic [SWR-1:0] d_q;
    logic [EWR-1:0] e_q;
    logic           c_q;
    logic           op_q;
    logic [SHW-1:0] lz_q;
    logic           rs_q;

    function automatic logic [SHW-1:0] lzc(input logic [SWR-1:0] v);
        logic [SHW-1:0] n;
        logic           hit;
        n   = '0;
        hit = 1'b0;
        for (int i = SWR - 1; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 1'b1;
            end
        end
        return n;
    endfunction

    logic [CW-1:0]  lz_w;
    logic [CW-1:0]  e_w;
    logic           clamp;
    logic [SHW-1:0] sh_amt;
    logic [EWR-1:0] e_left;
    logic [SWR-1:0] d_left;
    logic [EWR:0]   e_inc;
    logic           ovf;
    logic [EWR-1:0] e_right;
    logic [SWR-1:0] d_right;

    always_comb begin
        lz_w   = CW'(lz_q);
        e_w    = CW'(e_q);
        // Exponent cannot go below zero: stop shifting at Exp.
        clamp  = lz_w > e_w;
        sh_amt = clamp ? SHW'(e_q) : lz_q;
        e_left = clamp ? '0 : EWR'(e_w - lz_w);
        d_left = d_q << sh_amt;
        e_inc  = {1'b0, e_q} + 1'b1;
        // Saturate at all-ones; also covers Exp already all-ones.
        ovf     = e_inc >= {1'b0, {EWR{1'b1}}};
        e_right = ovf ? {EWR{1'b1}} : e_inc[EWR-1:0];
`ifdef NORM_STICKY_EN
        d_right = {1'b1, d_q[SWR-1:2], d_q[1] | d_q[0]};
`else
        d_right = {1'b1, d_q[SWR-1:1]};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            d_q         <= '0;
            e_q         <= '0;
            c_q         <= 1'b0;
            op_q        <= 1'b0;
            lz_q        <= '0;
            rs_q        <= 1'b0;
            Data_o      <= '0;
            Exp_o       <= '0;
            Shift_o     <= '0;
            busy_o      <= 1'b0;
            ready_o     <= 1'b0;
            zero_o      <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_i) begin
                        d_q    <= Data_i;
                        e_q    <= Exp_i;
                        c_q    <= C_i;
                        op_q   <= Add_Sub_op_i;
                        busy_o <= 1'b1;
                        state  <= COUNT;
                    end
                end
                COUNT: begin
                    lz_q  <= lzc(d_q);
                    // A carry on subtract is a positive difference.
                    rs_q  <= c_q & ~op_q;
                    state <= SHIFT;
                end
                SHIFT: begin
                    zero_o      <= 1'b0;
                    overflow_o  <= 1'b0;
                    underflow_o <= 1'b0;
                    if (rs_q) begin
                        Data_o     <= d_right;
                        Exp_o      <= e_right;
                        Shift_o    <= '0;
                        overflow_o <= ovf;
                    end else if (d_q == '0) begin
                        Data_o  <= '0;
                        Exp_o   <= '0;
                        Shift_o <= '0;
                        zero_o  <= 1'b1;
                    end else begin
                        Data_o      <= d_left;
                        Exp_o       <= e_left;
                        Shift_o     <= sh_amt;
                        underflow_o <= clamp;
                    end
                    busy_o <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
